// File: rtl/dpu_pkg.sv
// Shared types and constants for the data processing unit.
package dpu_pkg;

  // State codes double as the externally visible regime code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;
  localparam logic [1:0] MODE_ACC  = 2'b11;

endpackage

// File: rtl/dpu_datapath.sv
// Result, step counter and flag registers with the per-mode ALU.
module dpu_datapath
  import dpu_pkg::*;
#(
  parameter int W     = 8,
  parameter int STEPS = 7,
  parameter int SW    = $clog2(STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic          load,
  input  logic          op_en,
  input  logic [1:0]    mode_q,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b,
  output logic          last
);

  // Extra top bit captures the carry-out of the accumulate.
  logic [W:0] acc_sum;

  assign acc_sum = {1'b0, y} + {1'b0, x};
  assign last    = (s == SW'(STEPS - 1));

  // Load operand on start, otherwise apply one operation per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      s <= '0;
      b <= 1'b0;
    end else if (load) begin
      y <= x;
      s <= '0;
      b <= 1'b0;
    end else if (op_en) begin
      s <= s + SW'(1);
      case (mode_q)
        MODE_INC: begin
          y <= y + W'(1);
          if (y == '1) b <= 1'b1;
        end
        MODE_ROT: begin
          y <= {y[W-2:0], y[W-1]};
          b <= y[W-1];
        end
        MODE_ACC: begin
          y <= acc_sum[W-1:0];
          if (acc_sum[W]) b <= 1'b1;
        end
        default: begin
          // MODE_NONE never reaches RUN; registers hold.
        end
      endcase
    end
  end

endmodule

// File: rtl/data_proc_unit.sv
// Sequencing processing unit: FSM, latched mode and status decode.
module data_proc_unit
  import dpu_pkg::*;
#(
  parameter int W     = 8,
  parameter int STEPS = 7,
  parameter int SW    = $clog2(STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic [1:0]    on,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b,
  output logic          active,
  output logic [1:0]    regime,
  output logic          done,
  output logic [7:0]    real_state
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] mode_q;
  logic       load;
  logic       op_en;
  logic       last;

  assign load  = (state == IDLE) && start && (on != MODE_NONE);
  assign op_en = (state == RUN) && !abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Mode is captured only when a run is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mode_q <= MODE_NONE;
    else if (load) mode_q <= on;
  end

  // Next-state logic; abort wins over completing the last operation.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = RUN;
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  dpu_datapath #(
    .W     (W),
    .STEPS (STEPS),
    .SW    (SW)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .load   (load),
    .op_en  (op_en),
    .mode_q (mode_q),
    .y      (y),
    .s      (s),
    .b      (b),
    .last   (last)
  );

  assign regime     = state;
  assign active     = (state == RUN);
  assign done       = (state == DONE);
  assign real_state = {4'b0000, mode_q, regime};

endmodule

// File: tb/tb_data_proc_unit.sv
// Self-checking bench for data_proc_unit (default and W=16/STEPS=3 builds).
module tb_data_proc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  x8 = '0;
  logic [1:0]  on8 = '0;
  logic        start8 = 1'b0, abort8 = 1'b0;
  logic [7:0]  y8;
  logic [2:0]  s8;
  logic        b8, active8, done8;
  logic [1:0]  regime8;
  logic [7:0]  real8;

  logic [15:0] x16 = '0;
  logic [1:0]  on16 = '0;
  logic        start16 = 1'b0, abort16 = 1'b0;
  logic [15:0] y16;
  logic [1:0]  s16;
  logic        b16, active16, done16;
  logic [1:0]  regime16;
  logic [7:0]  real16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_proc_unit dut8 (
    .clk(clk), .rst(rst), .x(x8), .on(on8), .start(start8), .abort(abort8),
    .y(y8), .s(s8), .b(b8), .active(active8), .regime(regime8), .done(done8),
    .real_state(real8)
  );

  data_proc_unit #(.W(16), .STEPS(3)) dut16 (
    .clk(clk), .rst(rst), .x(x16), .on(on16), .start(start16), .abort(abort16),
    .y(y16), .s(s16), .b(b16), .active(active16), .regime(regime16), .done(done16),
    .real_state(real16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one operation of the given mode on a w-bit value, plain arithmetic.
  function automatic void model_step(input int w, input logic [1:0] m,
                                     input longint unsigned xv,
                                     inout longint unsigned yv, inout bit bv);
    longint unsigned modulus = 64'd1 << w;
    case (m)
      2'd1: begin
        if (yv == modulus - 1) bv = 1'b1;
        yv = (yv + 1) % modulus;
      end
      2'd2: begin
        bv = ((yv >> (w - 1)) & 1) != 0;
        yv = ((yv << 1) | (yv >> (w - 1))) % modulus;
      end
      2'd3: begin
        if (yv + xv >= modulus) bv = 1'b1;
        yv = (yv + xv) % modulus;
      end
      default: ;
    endcase
  endfunction

  // Full run on the 8-bit unit, checking every cycle against the model.
  task automatic run8(input logic [7:0] xv, input logic [1:0] m, input bit noisy,
                      input bit vary_x, output logic [7:0] yf, output logic bf);
    longint unsigned ym;
    bit bm;
    x8 = xv; on8 = m; start8 = 1'b1;
    tick();
    check("load_y8", y8, xv);
    check("load_regime8", regime8, 2'b01);
    check("load_active8", active8, 1'b1);
    check("load_real8", real8, {4'b0000, m, 2'b01});
    ym = xv; bm = 1'b0;
    start8 = noisy;
    for (int k = 1; k <= 7; k++) begin
      if (noisy) on8 = 2'($urandom_range(0, 3));
      if (vary_x) x8 = 8'($urandom);
      model_step(8, m, longint'(x8), ym, bm);
      tick();
      check("step_y8", y8, ym[7:0]);
      check("step_s8", s8, k);
      check("step_b8", b8, bm);
      check("step_done8", done8, k == 7);
      check("step_regime8", regime8, (k == 7) ? 2'b10 : 2'b01);
    end
    tick();
    start8 = 1'b0;
    check("idle_regime8", regime8, 2'b00);
    check("idle_done8", done8, 1'b0);
    check("idle_y8", y8, ym[7:0]);
    check("idle_s8", s8, 3'd7);
    yf = y8; bf = b8;
  endtask

  // Full run on the 16-bit, 3-step unit.
  task automatic run16(input logic [15:0] xv, input logic [1:0] m, input bit vary_x,
                       output logic [15:0] yf, output logic bf);
    longint unsigned ym;
    bit bm;
    x16 = xv; on16 = m; start16 = 1'b1;
    tick();
    start16 = 1'b0; on16 = 2'b00;
    check("load_y16", y16, xv);
    check("load_regime16", regime16, 2'b01);
    ym = xv; bm = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (vary_x) x16 = 16'($urandom);
      model_step(16, m, longint'(x16), ym, bm);
      tick();
      check("step_y16", y16, ym[15:0]);
      check("step_s16", s16, k);
      check("step_b16", b16, bm);
      check("step_done16", done16, k == 3);
      check("step_active16", active16, k != 3);
    end
    tick();
    check("idle_regime16", regime16, 2'b00);
    yf = y16; bf = b16;
  endtask

  initial begin
    logic [7:0]  yr8;
    logic [15:0] yr16;
    logic        br;

    // Reset state
    #1;
    check("rst_y8", y8, 8'h00);
    check("rst_s8", s8, 3'd0);
    check("rst_b8", b8, 1'b0);
    check("rst_regime8", regime8, 2'b00);
    check("rst_active8", active8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_real8", real8, 8'h00);
    check("rst_y16", y16, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // Directed test-plan runs
    run8(8'hFE, 2'b01, 1'b0, 1'b0, yr8, br);
    check("inc_final_y", yr8, 8'h05);
    check("inc_final_b", br, 1'b1);
    run8(8'h81, 2'b10, 1'b0, 1'b0, yr8, br);
    check("rot_final_y", yr8, 8'hC0);
    check("rot_final_b", br, 1'b0);
    run8(8'h30, 2'b11, 1'b1, 1'b0, yr8, br);
    check("acc_final_y", yr8, 8'h80);
    check("acc_final_b", br, 1'b1);

    // Abort at edge 3
    x8 = 8'h10; on8 = 2'b01; start8 = 1'b1;
    tick();
    start8 = 1'b0; on8 = 2'b00;
    tick();
    tick();
    check("abort_pre_done", done8, 1'b0);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    check("abort_y", y8, 8'h12);
    check("abort_s", s8, 3'd2);
    check("abort_regime", regime8, 2'b00);
    check("abort_done", done8, 1'b0);
    tick();
    check("abort_done_later", done8, 1'b0);

    // Start with mode none is ignored
    start8 = 1'b1; on8 = 2'b00;
    tick();
    start8 = 1'b0;
    check("none_regime", regime8, 2'b00);
    check("none_y", y8, 8'h12);
    check("none_s", s8, 3'd2);

    // Async reset between edges mid-run
    x8 = 8'h20; on8 = 2'b11; start8 = 1'b1;
    tick();
    start8 = 1'b0; on8 = 2'b00;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_y", y8, 8'h00);
    check("arst_s", s8, 3'd0);
    check("arst_b", b8, 1'b0);
    check("arst_regime", regime8, 2'b00);
    check("arst_active", active8, 1'b0);
    check("arst_done", done8, 1'b0);
    check("arst_real", real8, 8'h00);
    rst = 1'b0;
    tick();

    // Wide build: ACC of all-ones
    run16(16'hFFFF, 2'b11, 1'b0, yr16, br);
    check("w16_final_y", yr16, 16'hFFFC);
    check("w16_final_b", br, 1'b1);
    check("w16_final_s", s16, 2'd3);

    // Randomised runs against the model
    for (int i = 0; i < 6; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run8(8'($urandom), m, 1'($urandom), 1'($urandom), yr8, br);
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run16(16'($urandom), m, 1'($urandom), yr16, br);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
